// File: rtl/gen_con.sv
`default_nettype none
// ============================================================================
// Module   : gen_con
// Purpose  : Keypad calculator controller. Two decimal operands, add/sub/mul,
//            sign-magnitude result for the 16-bit display.
// Revision : 1.0
// ============================================================================
module gen_con (
   input  logic        clk,
   input  logic        nRST,
   input  logic [3:0]  keypad_input,
   input  logic        read_input,
   input  logic [2:0]  operator_input,
   input  logic        equal_input,
   output logic        complete,
   output logic [15:0] display_output,
   output logic [3:0]  tb_current_state
);

   typedef enum logic [3:0] {
      SEND_MULT_OP1_START = 4'd0,
      MULT_OP1            = 4'd1,
      SEND_MULT_OP2_START = 4'd2,
      MULT_OP2            = 4'd3,
      COMPUTE             = 4'd4,
      DONE                = 4'd5
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b100;

   state_t      state;
   logic [15:0] op1, op2, result;
   logic [15:0] mcand, mplier, acc;
   logic [2:0]  op;
   logic [3:0]  digit;
   logic [3:0]  cnt;
   logic        read_prev;

   logic        rd_evt;
   logic        op_valid;
   logic [15:0] op1_next, op2_next, acc_next;

   assign rd_evt   = read_input & ~read_prev & (keypad_input <= 4'd9);
   assign op_valid = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
                     (operator_input == OP_MUL);
   assign op1_next = (op1 << 3) + (op1 << 1) + {12'd0, digit};
   assign op2_next = (op2 << 3) + (op2 << 1) + {12'd0, digit};
   assign acc_next = acc + (mplier[0] ? mcand : 16'd0);

   assign tb_current_state = state;

   function automatic logic [15:0] to_sm(input logic [15:0] v);
      logic [15:0] n;
      n = -v;
      to_sm = {v[15], (v[15] ? n[14:0] : v[14:0])};
   endfunction

   always_ff @(posedge clk) begin
      if (nRST) begin
         state          <= SEND_MULT_OP1_START;
         op1            <= 16'd0;
         op2            <= 16'd0;
         result         <= 16'd0;
         op             <= 3'd0;
         digit          <= 4'd0;
         read_prev      <= 1'b0;
         mcand          <= 16'd0;
         mplier         <= 16'd0;
         acc            <= 16'd0;
         cnt            <= 4'd0;
         complete       <= 1'b0;
         display_output <= 16'd0;
      end else begin
         read_prev <= read_input;
         case (state)
            SEND_MULT_OP1_START: begin
               if (rd_evt) begin
                  digit <= keypad_input;
                  state <= MULT_OP1;
               end else if (op_valid) begin
                  op             <= operator_input;
                  state          <= SEND_MULT_OP2_START;
                  display_output <= to_sm(op2);
               end
            end
            MULT_OP1: begin
               op1            <= op1_next;
               display_output <= to_sm(op1_next);
               state          <= SEND_MULT_OP1_START;
            end
            SEND_MULT_OP2_START: begin
               if (rd_evt) begin
                  digit <= keypad_input;
                  state <= MULT_OP2;
               end else if (equal_input) begin
                  // Seed the shift-add multiplier; unused for add/sub.
                  acc    <= 16'd0;
                  mcand  <= op1;
                  mplier <= op2;
                  cnt    <= 4'd0;
                  state  <= COMPUTE;
               end
            end
            MULT_OP2: begin
               op2            <= op2_next;
               display_output <= to_sm(op2_next);
               state          <= SEND_MULT_OP2_START;
            end
            COMPUTE: begin
               if (op == OP_ADD) begin
                  result <= op1 + op2;
                  state  <= DONE;
               end else if (op == OP_SUB) begin
                  result <= op1 - op2;
                  state  <= DONE;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     result <= acc_next;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               complete       <= 1'b1;
               display_output <= to_sm(result);
            end
            default: state <= SEND_MULT_OP1_START;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gen_con.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_con
// Purpose  : Randomised and directed bench for gen_con against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_gen_con;

   logic        clk;
   logic        nRST;
   logic [3:0]  keypad_input;
   logic        read_input;
   logic [2:0]  operator_input;
   logic        equal_input;
   logic        complete;
   logic [15:0] display_output;
   logic [3:0]  tb_current_state;

   int nchecks = 0;
   int nerrors = 0;
   bit checking = 0;

   gen_con dut (
      .clk              (clk),
      .nRST             (nRST),
      .keypad_input     (keypad_input),
      .read_input       (read_input),
      .operator_input   (operator_input),
      .equal_input      (equal_input),
      .complete         (complete),
      .display_output   (display_output),
      .tb_current_state (tb_current_state)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the calculator's observable behaviour.
   int  m_state, m_op1, m_op2, m_res, m_op, m_dig, m_lat, m_disp;
   bit  m_prev, m_cmp;

   function automatic int sm(input int v);
      int mag;
      if (v >= 32768) begin
         mag = (65536 - v) % 32768;
         return 32768 + mag;
      end
      return v;
   endfunction

   function automatic int calc(input int a, input int b, input int o);
      longint p;
      if (o == 1) return (a + b) % 65536;
      if (o == 2) return (a - b + 65536) % 65536;
      p = longint'(a) * longint'(b);
      return int'(p % 65536);
   endfunction

   always @(posedge clk) begin
      bit rd;
      if (nRST) begin
         m_state = 0; m_op1 = 0; m_op2 = 0; m_res = 0; m_op = 0; m_dig = 0;
         m_lat = 0; m_disp = 0; m_prev = 0; m_cmp = 0;
      end else begin
         rd = read_input && !m_prev && (keypad_input <= 9);
         m_prev = read_input;
         case (m_state)
            0: if (rd) begin m_dig = keypad_input; m_state = 1; end
               else if (operator_input == 1 || operator_input == 2 || operator_input == 4) begin
                  m_op = operator_input; m_state = 2; m_disp = sm(m_op2);
               end
            1: begin m_op1 = (m_op1 * 10 + m_dig) % 65536; m_disp = sm(m_op1); m_state = 0; end
            2: if (rd) begin m_dig = keypad_input; m_state = 3; end
               else if (equal_input) begin m_state = 4; m_lat = (m_op == 4) ? 16 : 1; end
            3: begin m_op2 = (m_op2 * 10 + m_dig) % 65536; m_disp = sm(m_op2); m_state = 2; end
            4: begin
               m_lat--;
               if (m_lat == 0) begin m_res = calc(m_op1, m_op2, m_op); m_state = 5; end
            end
            default: begin m_cmp = 1; m_disp = sm(m_res); end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      if (checking) begin
         check("state", 32'(tb_current_state), 32'(m_state));
         check("complete", 32'(complete), 32'(m_cmp));
         check("display", 32'(display_output), 32'(m_disp));
      end
   end

   task automatic do_reset();
      @(negedge clk); nRST = 1;
      @(negedge clk); nRST = 0;
   endtask

   task automatic press_digit(input logic [3:0] d, input int hold);
      @(negedge clk); keypad_input = d; read_input = 1;
      repeat (hold - 1) @(negedge clk);
      @(negedge clk); read_input = 0;
      @(negedge clk);
   endtask

   task automatic press_op(input logic [2:0] o);
      @(negedge clk); operator_input = o;
      @(negedge clk); operator_input = 3'd0;
   endtask

   // Returns cycles from the sampling edge of equal until complete is seen.
   task automatic press_eq(output int lat);
      @(negedge clk); equal_input = 1;
      @(posedge clk);
      lat = 0;
      @(negedge clk); equal_input = 0;
      while (!complete && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (lat >= 40) begin
         nchecks++; nerrors++;
         $display("FAIL eq_timeout: got no complete expected complete within 40 cycles");
      end
   endtask

   task automatic enter_num(input int v);
      int ds[$];
      if (v == 0) ds.push_back(0);
      while (v > 0) begin ds.push_front(v % 10); v = v / 10; end
      foreach (ds[i]) press_digit(4'(ds[i]), 1);
   endtask

   task automatic calc_lit(input int a, input logic [2:0] o, input int b,
                           input logic [15:0] exp, input int exp_lat, input string nm);
      int lat;
      do_reset();
      enter_num(a);
      press_op(o);
      enter_num(b);
      press_eq(lat);
      check({nm, "_disp"}, 32'(display_output), 32'(exp));
      check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      int lat, nd, o;
      logic [2:0] ops [3];
      ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100;
      nRST = 1; keypad_input = 0; read_input = 0; operator_input = 0; equal_input = 0;
      @(negedge clk);
      checking = 1;
      check("rst_state", 32'(tb_current_state), 32'd0);
      check("rst_disp", 32'(display_output), 32'd0);
      check("rst_complete", 32'(complete), 32'd0);
      nRST = 0;

      calc_lit(11, 3'b001, 23, 16'h0022, 2, "add_11_23");
      calc_lit(3, 3'b010, 5, 16'h8002, 2, "sub_3_5");
      calc_lit(4, 3'b100, 3, 16'h000C, 17, "mul_4_3");
      calc_lit(128, 3'b100, 256, 16'h8000, 17, "mul_wrap");
      calc_lit(999, 3'b010, 0, 16'h03E7, 2, "sub_999_0");

      // Held strobe, out-of-range key and early equal.
      do_reset();
      press_digit(4'd7, 5);
      check("held_strobe", 32'(display_output), 32'h7);
      press_digit(4'd12, 1);
      check("key12_ignored", 32'(display_output), 32'h7);
      @(negedge clk); equal_input = 1;
      @(negedge clk); equal_input = 0;
      check("eq_in_op1", 32'(tb_current_state), 32'd0);

      // Reset in the middle of a multiply.
      do_reset();
      enter_num(4); press_op(3'b100); enter_num(3);
      @(negedge clk); equal_input = 1;
      @(negedge clk); equal_input = 0;
      repeat (5) @(negedge clk);
      check("mid_mul_state", 32'(tb_current_state), 32'd4);
      nRST = 1;
      @(posedge clk); #1;
      check("mulrst_state", 32'(tb_current_state), 32'd0);
      check("mulrst_disp", 32'(display_output), 32'd0);
      check("mulrst_cmp", 32'(complete), 32'd0);
      @(negedge clk); nRST = 0;
      enter_num(2); press_op(3'b001); enter_num(3);
      press_eq(lat);
      check("after_rst_add", 32'(display_output), 32'h0005);

      // Randomised calculations with noise, checked cycle by cycle by the model.
      for (int t = 0; t < 25; t++) begin
         do_reset();
         nd = $urandom_range(0, 5);
         for (int i = 0; i < nd; i++) press_digit(4'($urandom_range(0, 9)), $urandom_range(1, 3));
         if ($urandom_range(0, 2) == 0) press_digit(4'($urandom_range(10, 15)), 1);
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk); equal_input = 1;
            @(negedge clk); equal_input = 0;
         end
         o = $urandom_range(0, 2);
         press_op(ops[o]);
         nd = $urandom_range(0, 5);
         for (int i = 0; i < nd; i++) press_digit(4'($urandom_range(0, 9)), $urandom_range(1, 3));
         press_eq(lat);
         check("rand_lat", 32'(lat), (o == 2) ? 32'd17 : 32'd2);
         repeat (3) @(negedge clk);
      end

      @(negedge clk);
      checking = 0;
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gen_con.md
# gen_con

Keypad-driven 16-bit signed calculator controller. Accumulates two decimal operands one digit at a time, latches an operator (add, subtract, multiply), and computes on an equal press. The result is presented in sign-magnitude form for the display driver. It sits between the keypad/button decoders and the 16-bit display.

## Interface
- No parameters.
- `clk` in 1: system clock; all logic on the rising edge.
- `nRST` in 1: synchronous, active-high reset. Codebase name retained; `1` resets at the next rising edge.
- `keypad_input` in 4: decimal digit, 0–9; values 10–15 ignored.
- `read_input` in 1: digit strobe; digit is captured on the rising edge of this strobe.
- `operator_input` in 3: one-hot operator; `001` add, `010` subtract, `100` multiply; any other value means "none".
- `equal_input` in 1: compute request (level).
- `complete` out 1: high while the result is valid.
- `display_output` out 16: sign-magnitude value; bit 15 is the sign, [14:0] is the magnitude.
- `tb_current_state` out 4: current FSM state encoding, for debug and bench synchronisation.

## Operation
- **States (encoding):**
  - `SEND_MULT_OP1_START`=0: idle, waiting for an op1 digit.
  - `MULT_OP1`=1: op1 accumulate cycle.
  - `SEND_MULT_OP2_START`=2: waiting for an op2 digit.
  - `MULT_OP2`=3: op2 accumulate cycle.
  - `COMPUTE`=4.
  - `DONE`=5.
  - Unused codes go to state 0.
- **Strobe edge detect:** `read_prev` register; `rd_evt = read_input & ~read_prev & (keypad_input<=9)`.
- **OP1_START:**
  - `rd_evt`: latch the digit, go to `MULT_OP1`.
  - Else, valid one-hot operator: latch the operator, go to `OP2_START`.
  - Else, stay.
- **MULT_OP1:** `op1 <= op1*10 + digit`, computed as `(op1<<3)+(op1<<1)+digit`, modulo 2^16. Return to `OP1_START`.
- **OP2_START:**
  - `rd_evt`: latch the digit, go to `MULT_OP2`.
  - Else, `equal_input`=1: go to `COMPUTE`.
  - `operator_input` is ignored here.
- **MULT_OP2:** same accumulate step on `op2`. Return to `OP2_START`.
- **Operands:** 16-bit two's complement. Entry values of 32768 and above wrap negative. An operand with no digits entered is 0.
- **COMPUTE:**
  - add / sub: `result = op1 ± op2` modulo 2^16, one cycle.
  - mul: iterative shift-add, 16 iterations (one multiplier bit per cycle). The 16-bit product is truncated to the low 16 bits (signed wrap).
  - Then go to `DONE`.
- **DONE:**
  - `complete`=1.
  - `display_output` holds the result.
  - Stays until reset; all inputs are ignored.
- **Display, sign-magnitude of:**
  - op1 in states 0–1.
  - op2 in states 2–3.
  - The held previous value in `COMPUTE`.
  - `result` in `DONE`.
  - Conversion: `sign = v[15]`, `mag = v[15] ? (-v)[14:0] : v[14:0]`. Therefore −32768 displays as `16'h8000`.
- **Reset:** from any state, including mid-multiply:
  - state=0
  - op1, op2, result, operator, digit, `read_prev` = 0
  - `complete`=0
  - `display_output`=0
  - `tb_current_state`=0

## Timing
- A `rd_evt` sampled at edge N puts the FSM in the MULT state after N. After N+1 it is back in START with the updated operand. The display shows the new operand from N+1.
- A strobe held high for several cycles counts as one digit. A new digit requires `read_input` to fall first.
- Digit and operator in the same OP1_START cycle: the digit wins; the operator is re-evaluated on the next START cycle (if still asserted).
- Digit and equal in the same OP2_START cycle: the digit wins.
- Equal sampled at edge E:
  - add/sub: `complete`=1 after E+2.
  - mul: `complete`=1 after E+17.
- `equal_input` in states 0–1 is ignored.
- Latency does not depend on operand values.

## Test plan
- Reset, digits 1,1, op `001`, digits 2,3, equal → `complete`=1, `display_output`=`16'h0022` (34).
- Digit 3, op `010`, digit 5, equal → `16'h8002` (−2).
- Digit 4, op `100`, digit 3, equal → `16'h000C` after exactly 17 cycles from equal.
- Digits 1,2,8, op `100`, digits 2,5,6, equal → product wraps, `16'h8000`. Also 9,9,9 `010` 0 → `16'h03E7`.
- `read_input` held high for 5 cycles with digit 7 → op1=7, not 77. Keypad value 12 strobed → ignored. `equal_input` in OP1_START → no state change.
- Assert `nRST` during a multiply `COMPUTE` → next cycle state 0, all outputs 0. A following calculation of 2+3 gives `16'h0005`.
